sequence_gen_tx: RTL and testbench
==================================

// Module: sequence_gen_tx
//
// PURPOSE
//   Serial pattern transmitter. It is the source-side counterpart of the team's
//   serial sequence detectors.
//   - On a start request it shifts a fixed PAT_W-bit pattern onto a 1-bit data
//     line, MSB first, one bit per clk.
//   - It sends the pattern a programmable number of times, with optional idle
//     gap cycles between copies.
//   - Uses: stimulus generator for detector blocks, and a framing-preamble source
//     on serial links.
//
// PARAMETERS
//   PAT_W     5         pattern length in bits (>=2)
//   PATTERN   5'b10111  pattern value; bit PAT_W-1 is sent first
//   REP_W     4         width of the repeat-count input
//   GAP_CYC   1         idle cycles inserted between consecutive copies (0 = back-to-back)
//
// PORTS
//   clk         in   1      clock, rising edge
//   rst         in   1      asynchronous, active-low reset
//   start       in   1      request to transmit; sampled only in IDLE
//   rep_num     in   REP_W  number of copies to send; latched with start; 0 is treated as 1
//   data        out  1      serial output bit (registered)
//   data_valid  out  1      high while data carries a pattern bit (registered)
//   busy        out  1      high from the cycle after start until done (registered)
//   done        out  1      1-cycle pulse after the last bit of the last copy (registered)
//
// BEHAVIOUR
//   Reset
//     - rst low forces state IDLE immediately, asynchronously.
//     - All counters clear to 0; data, data_valid, busy and done all go to 0.
//     - Reset mid-transfer aborts the transfer: no done pulse, no residual bits.
//   States
//     - IDLE: data=0, data_valid=0, busy=0.
//         start=1 -> SEND; latch rep_num (0 -> 1) into rep_cnt; clear bit_cnt.
//     - SEND: data=PATTERN[PAT_W-1-bit_cnt], data_valid=1, busy=1; bit_cnt increments every cycle.
//         On the last bit (bit_cnt==PAT_W-1), with rep_cnt decremented:
//           rep_cnt>1 and GAP_CYC>0  -> GAP
//           rep_cnt>1 and GAP_CYC==0 -> stay in SEND, bit_cnt wraps to 0
//           rep_cnt==1               -> DONE
//     - GAP: data=0, data_valid=0, busy=1 for exactly GAP_CYC cycles, then SEND with bit_cnt=0.
//     - DONE: exactly 1 cycle; done=1, busy=0, data_valid=0, data=0; then IDLE.
//   Timing
//     - start=1 in IDLE at cycle N -> first pattern bit on data at cycle N+1.
//     - A single-copy transfer puts its last bit at N+PAT_W and done=1 at N+PAT_W+1.
//     - Total cycles from start to done = rep*PAT_W + (rep-1)*GAP_CYC + 1.
//     - A new start is accepted in IDLE, i.e. earliest at N+PAT_W+2 for one copy.
//   Boundaries
//     - start while busy or in DONE is ignored; it is not queued.
//     - rep_num changes after latching have no effect on the current transfer.
//     - rep_num = 2^REP_W-1 must send exactly that many copies (counter must not overflow).
//     - start held high continuously: a new transfer begins in each IDLE cycle,
//       i.e. one IDLE cycle between done and the next first bit.
//     - Unused state encodings -> IDLE.
//   Widths
//     - bit_cnt is $clog2(PAT_W) bits; gap_cnt is $clog2(GAP_CYC+1) bits (min 1); rep_cnt is REP_W bits.
//
// TESTING
//   1. Reset: rst=0 for 3 cycles, then release -> data=0, data_valid=0, busy=0, done=0,
//      and they stay 0 with no start.
//   2. Single copy: start=1 at cycle N, rep_num=1 -> data = 1,0,1,1,1 at N+1..N+5 with
//      data_valid=1; done=1 only at N+6; busy=1 at N+1..N+5.
//   3. Repeat with gap: rep_num=3, GAP_CYC=1 -> 10111,(gap 0),10111,(gap 0),10111;
//      data_valid low on the 2 gap cycles; done at N+18.
//   4. rep_num=0 -> identical to rep_num=1.
//      Start pulses at N+2 and N+4 during a transfer -> ignored; exactly 5 valid bits and one done.
//   5. Abort: rst pulsed low at N+3 of a rep_num=2 transfer -> outputs 0 at once, no done;
//      next start then produces a full clean transfer.
//   6. Loopback: data drives the team's 10111 sequence detector, GAP_CYC=1, rep_num=4 ->
//      the detector flag pulses exactly 4 times, each one cycle after the last bit of a copy.

Source files
------------

// File: rtl/sequence_gen_tx.sv
// Serial pattern transmitter: shifts PATTERN out MSB first, rep_num times,
// with GAP_CYC idle cycles between copies. All outputs are registered.
module sequence_gen_tx #(
    parameter int              PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b10111,
    parameter int              REP_W   = 4,
    parameter int              GAP_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [REP_W-1:0] rep_num,
    output logic             data,
    output logic             data_valid,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(PAT_W);
    localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t             state_q, state_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
    logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic               data_q, data_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [PAT_W-1:0]   pat_rev;

    // Bit-reversed pattern so bit_cnt indexes the transmit order directly.
    for (genvar g = 0; g < PAT_W; g++) begin : g_rev
        assign pat_rev[g] = PATTERN[PAT_W-1-g];
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        rep_cnt_d = rep_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SEND;
                    bit_cnt_d = '0;
                    rep_cnt_d = (rep_num == '0) ? REP_W'(1) : rep_num;
                end
            end
            SEND: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    // rep_cnt holds copies still to send including this one, so max value never overflows.
                    if (rep_cnt_q > REP_W'(1)) begin
                        rep_cnt_d = rep_cnt_q - REP_W'(1);
                        if (GAP_CYC > 0) begin
                            state_d   = GAP;
                            gap_cnt_d = '0;
                        end
                    end else begin
                        rep_cnt_d = '0;
                        state_d   = DONE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = SEND;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it after the edge.
    always_comb begin
        data_d  = (state_d == SEND) && pat_rev[bit_cnt_d];
        valid_d = (state_d == SEND);
        busy_d  = (state_d == SEND) || (state_d == GAP);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            rep_cnt_q <= '0;
            data_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sequence_gen_tx.sv
// Bench for sequence_gen_tx: queue-based model of the expected output stream,
// directed timing cases, abort, loopback into a 10111 detector, random traffic.
module tb_sequence_gen_tx;

    localparam int PAT_W = 5;
    localparam logic [PAT_W-1:0] PATTERN = 5'b10111;
    localparam int REP_W = 4;
    localparam int GAP_CYC = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [REP_W-1:0] rep_num = '0;
    logic data, data_valid, busy, done;

    int pass_cnt = 0;
    int total_cnt = 0;
    int flag_cnt = 0;

    // expected {data, data_valid, busy, done} per cycle, queued at acceptance
    logic [3:0] exp_q[$];
    logic [3:0] exp_o;

    logic [4:0] hist;
    logic       flag;

    sequence_gen_tx #(.PAT_W(PAT_W), .PATTERN(PATTERN), .REP_W(REP_W), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .rst(rst), .start(start), .rep_num(rep_num),
        .data(data), .data_valid(data_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Stand-in for the downstream 10111 detector: registered flag on match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            flag <= 1'b0;
        end else begin
            hist <= {hist[3:0], data};
            flag <= ({hist[3:0], data} == 5'b10111);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic push_xfer(input logic [REP_W-1:0] r);
        int n;
        n = (r == 0) ? 1 : int'(r);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < PAT_W; i++) exp_q.push_back({PATTERN[PAT_W-1-i], 3'b110});
            if (c < n - 1)
                for (int gi = 0; gi < GAP_CYC; gi++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
        // DONE is followed by at least one IDLE cycle before the next acceptance
        exp_q.push_back(4'b0000);
    endtask

    task automatic check_outs(input logic [3:0] e);
        chk("data", int'(data), int'(e[3]));
        chk("data_valid", int'(data_valid), int'(e[2]));
        chk("busy", int'(busy), int'(e[1]));
        chk("done", int'(done), int'(e[0]));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) exp_q.delete();
        else if (exp_q.size() == 0 && start) push_xfer(rep_num);
        exp_o = (rst && exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
        #1;
        check_outs(exp_o);
        if (flag) flag_cnt++;
    endtask

    // Start one transfer, then run until done; checks copy count and latency.
    task automatic run_xfer(input logic [REP_W-1:0] r, input bit extra_starts);
        int n, t, vbits, dones;
        bit seen;
        n = (r == 0) ? 1 : int'(r);
        vbits = 0; dones = 0; seen = 0; t = 0;
        start = 1'b1; rep_num = r;
        while (!seen && t < 400) begin
            tick();
            t++;
            start = extra_starts && (t == 2 || t == 4);
            rep_num = REP_W'($urandom);
            if (data_valid) vbits++;
            if (done) begin dones++; seen = 1; end
        end
        chk("start_to_done", t, n * PAT_W + (n - 1) * GAP_CYC + 1);
        chk("valid_bits", vbits, n * PAT_W);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done) dones++;
        end
        chk("done_pulses", dones, 1);
    endtask

    initial begin
        // reset held low for 3 cycles, released away from the edge
        for (int k = 0; k < 3; k++) tick();
        #2 rst = 1'b1;
        for (int k = 0; k < 4; k++) tick();

        run_xfer(4'd1, 1'b0);
        run_xfer(4'd3, 1'b0);
        run_xfer(4'd0, 1'b1);
        run_xfer(4'd15, 1'b0);

        // abort mid-transfer: async reset clears outputs before any edge
        start = 1'b1; rep_num = 4'd2;
        tick();
        start = 1'b0;
        tick(); tick();
        #1 rst = 1'b0;
        #1 check_outs(4'b0000);
        tick();
        #2 rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("no_done_after_abort", int'(done), 0);
        end
        run_xfer(4'd2, 1'b0);

        // loopback into the detector
        flag_cnt = 0;
        run_xfer(4'd4, 1'b0);
        chk("detector_hits", flag_cnt, 4);

        // start held high: back-to-back transfers with one IDLE between
        start = 1'b1; rep_num = 4'd1;
        for (int k = 0; k < 30; k++) tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();

        // random traffic, rep_num changing every cycle
        for (int k = 0; k < 500; k++) begin
            start = ($urandom_range(0, 3) == 0);
            rep_num = REP_W'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
